// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester, flush/ready and memory-controller signals of mem_arbiter
interface mem_arbiter_if;
  logic        rdy_in;
  logic        rob_clear;
  logic        io_buffer_full;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        lsb_req;
  logic        lsb_we;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_wdata;
  logic [2:0]  lsb_type;
  logic        lsb_done;
  logic [31:0] lsb_rdata;
  logic        mc_new_task;
  logic        mc_is_write;
  logic [31:0] mc_addr;
  logic [31:0] mc_wdata;
  logic [2:0]  mc_work_type;
  logic [31:0] mc_rdata;
  logic        mc_ready;
  logic        mc_working;
  modport slave (
    input  rdy_in, rob_clear, io_buffer_full, if_req, if_addr, lsb_req, lsb_we, lsb_addr,
           lsb_wdata, lsb_type, mc_rdata, mc_ready, mc_working,
    output if_done, if_data, lsb_done, lsb_rdata, mc_new_task, mc_is_write, mc_addr,
           mc_wdata, mc_work_type
  );
  modport master (
    output rdy_in, rob_clear, io_buffer_full, if_req, if_addr, lsb_req, lsb_we, lsb_addr,
           lsb_wdata, lsb_type, mc_rdata, mc_ready, mc_working,
    input  if_done, if_data, lsb_done, lsb_rdata, mc_new_task, mc_is_write, mc_addr,
           mc_wdata, mc_work_type
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates fetch and LSB requests onto one byte-serial memory controller
// Optional MEM_ARB_PERF_EN adds grant and IO-stall performance counters.
module mem_arbiter #(
  parameter logic [31:0] IO_BASE      = 32'h0003_0000,
  parameter logic [2:0]  IF_WORK_TYPE = 3'b010
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
`ifdef MEM_ARB_PERF_EN
  output logic [31:0]  perf_if_grants,
  output logic [31:0]  perf_lsb_grants,
  output logic [31:0]  perf_io_stall,
`endif
  mem_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_LSB = 1'b1;
  logic [1:0]  state_q, state_d;
  logic        last_q, last_d, owner_q, owner_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [2:0]  wt_q, wt_d;
  logic        if_done_q, if_done_d, lsb_done_q, lsb_done_d;
  logic [31:0] if_data_q, if_data_d, lsb_rdata_q, lsb_rdata_d;
  logic        io_block, lsb_st, if_ok, lsb_ok, pick_lsb, grant, flush_rd, issue, finish;
  assign io_block = bus.lsb_req && bus.lsb_we && bus.lsb_addr >= IO_BASE && bus.io_buffer_full;
  assign lsb_st   = bus.lsb_req && bus.lsb_we && !io_block;
  assign if_ok    = bus.if_req && !bus.rob_clear;
  assign lsb_ok   = lsb_st || (bus.lsb_req && !bus.lsb_we && !bus.rob_clear);
  assign pick_lsb = lsb_st || (lsb_ok && (!if_ok || last_q == OWN_IF));
  assign grant    = if_ok || lsb_ok;
  assign flush_rd = bus.rob_clear && !we_q;
  assign issue    = state_q == ISSUE && bus.rdy_in && !bus.rob_clear && !bus.mc_working;
  assign finish   = state_q == WAIT && !flush_rd && !bus.mc_working && (we_q || bus.mc_ready);
  // next state: grant and latch the task in IDLE, strobe in ISSUE, complete or abort in WAIT
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wt_d        = wt_q;
    if_data_d   = if_data_q;
    lsb_rdata_d = lsb_rdata_q;
    if_done_d   = 1'b0;
    lsb_done_d  = 1'b0;
    if (state_q == IDLE && grant) begin
      state_d = ISSUE;
      owner_d = pick_lsb;
      last_d  = pick_lsb;
      we_d    = pick_lsb && bus.lsb_we;
      addr_d  = pick_lsb ? bus.lsb_addr : bus.if_addr;
      wdata_d = pick_lsb ? bus.lsb_wdata : '0;
      wt_d    = pick_lsb ? bus.lsb_type : IF_WORK_TYPE;
    end
    if (state_q == ISSUE) state_d = flush_rd ? IDLE : issue ? WAIT : ISSUE;
    if (state_q == WAIT && (flush_rd || finish)) state_d = IDLE;
    if (finish) begin
      if_done_d   = owner_q == OWN_IF;
      lsb_done_d  = owner_q == OWN_LSB;
      if_data_d   = owner_q == OWN_IF && !we_q ? bus.mc_rdata : if_data_q;
      lsb_rdata_d = owner_q == OWN_LSB && !we_q ? bus.mc_rdata : lsb_rdata_q;
    end
  end
  // all state and output registers hold while rdy_in is low
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= IDLE;
      last_q      <= OWN_LSB;
      owner_q     <= OWN_IF;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wt_q        <= '0;
      if_done_q   <= 1'b0;
      lsb_done_q  <= 1'b0;
      if_data_q   <= '0;
      lsb_rdata_q <= '0;
    end else if (bus.rdy_in) begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wt_q        <= wt_d;
      if_done_q   <= if_done_d;
      lsb_done_q  <= lsb_done_d;
      if_data_q   <= if_data_d;
      lsb_rdata_q <= lsb_rdata_d;
    end
  end
  assign bus.mc_new_task  = issue;
  assign bus.mc_is_write  = we_q;
  assign bus.mc_addr      = addr_q;
  assign bus.mc_wdata     = wdata_q;
  assign bus.mc_work_type = wt_q;
  assign bus.if_done      = if_done_q;
  assign bus.if_data      = if_data_q;
  assign bus.lsb_done     = lsb_done_q;
  assign bus.lsb_rdata    = lsb_rdata_q;
  // a new task must never be strobed into a busy controller
  assert property (@(posedge clk_in) disable iff (!rst_n_in) !(bus.mc_new_task && bus.mc_working));
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if_q, perf_lsb_q, perf_io_q;
  // free-running counters of grants per owner and IDLE cycles with an IO store held off
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      perf_if_q  <= '0;
      perf_lsb_q <= '0;
      perf_io_q  <= '0;
    end else if (bus.rdy_in) begin
      perf_if_q  <= perf_if_q + {31'd0, state_q == IDLE && grant && !pick_lsb};
      perf_lsb_q <= perf_lsb_q + {31'd0, state_q == IDLE && grant && pick_lsb};
      perf_io_q  <= perf_io_q + {31'd0, state_q == IDLE && io_block};
    end
  end
  assign perf_if_grants  = perf_if_q;
  assign perf_lsb_grants = perf_lsb_q;
  assign perf_io_stall   = perf_io_q;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed cycle-exact checks of mem_arbiter against a byte-serial controller model
module tb_mem_arbiter;
  logic clk_in = 1'b0;
  logic rst_n_in;
  logic [31:0] rdata_v;
  int checks = 0;
  int passes = 0;
  int overlap = 0;
  mem_arbiter_if bus();
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if_grants, perf_lsb_grants, perf_io_stall;
`endif
  mem_arbiter dut (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
`ifdef MEM_ARB_PERF_EN
    .perf_if_grants(perf_if_grants),
    .perf_lsb_grants(perf_lsb_grants),
    .perf_io_stall(perf_io_stall),
`endif
    .bus(bus)
  );
  always #5 clk_in = ~clk_in;
  // controller model: byte ends in the first busy-free cycle, half one cycle later, word two
  logic       m_act, m_we;
  logic [1:0] m_cnt;
  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      m_act <= 1'b0;
      m_we  <= 1'b0;
      m_cnt <= 2'd0;
    end else if (bus.rdy_in) begin
      if (bus.mc_new_task) begin
        m_act <= 1'b1;
        m_we  <= bus.mc_is_write;
        m_cnt <= bus.mc_work_type[1:0];
      end else if (m_act) begin
        if (m_cnt != 2'd0) m_cnt <= m_cnt - 2'd1;
        else m_act <= 1'b0;
      end
    end
  end
  always @(posedge clk_in) if (bus.mc_new_task && bus.mc_working) overlap <= overlap + 1;
  assign bus.mc_working = m_act && m_cnt != 2'd0;
  assign bus.mc_ready   = m_act && m_cnt == 2'd0 && !m_we;
  assign bus.mc_rdata   = rdata_v;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask
  task automatic smp();
    @(negedge clk_in);
  endtask
  initial begin
    rst_n_in = 1'b0;
    rdata_v = '0;
    bus.rdy_in = 1'b1;
    bus.rob_clear = 1'b0;
    bus.io_buffer_full = 1'b0;
    bus.if_req = 1'b0;
    bus.if_addr = '0;
    bus.lsb_req = 1'b0;
    bus.lsb_we = 1'b0;
    bus.lsb_addr = '0;
    bus.lsb_wdata = '0;
    bus.lsb_type = '0;
    #12;
    chk("rst_if_done", bus.if_done, 0);
    chk("rst_lsb_done", bus.lsb_done, 0);
    chk("rst_new_task", bus.mc_new_task, 0);
    chk("rst_mc_addr", bus.mc_addr, 0);
    chk("rst_work_type", bus.mc_work_type, 0);
    chk("rst_if_data", bus.if_data, 0);
    cyc();
    rst_n_in = 1'b1;
    // fetch alone, word latency
    cyc();
    bus.if_req = 1'b1; bus.if_addr = 32'h100; rdata_v = 32'hDEADBEEF;
    smp(); chk("f_c0_task", bus.mc_new_task, 0);
    cyc(); smp();
    chk("f_issue", bus.mc_new_task, 1);
    chk("f_wt", bus.mc_work_type, 3'b010);
    chk("f_addr", bus.mc_addr, 32'h100);
    chk("f_dir", bus.mc_is_write, 0);
    cyc(); cyc(); cyc(); smp(); chk("f_c4_done", bus.if_done, 0);
    cyc(); bus.if_req = 1'b0;
    smp(); chk("f_done", bus.if_done, 1); chk("f_data", bus.if_data, 32'hDEADBEEF);
    cyc(); smp(); chk("f_pulse", bus.if_done, 0);
    // IO store held off by a full UART buffer for 10 cycles
    cyc();
    bus.lsb_req = 1'b1; bus.lsb_we = 1'b1; bus.lsb_addr = 32'h30000; bus.lsb_wdata = 32'h55;
    bus.lsb_type = 3'b000; bus.io_buffer_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      smp(); chk("io_held", bus.mc_addr, 32'h100);
      cyc();
    end
    bus.io_buffer_full = 1'b0;
    smp(); chk("io_c10_task", bus.mc_new_task, 0);
    cyc(); smp();
    chk("io_issue", bus.mc_new_task, 1);
    chk("io_dir", bus.mc_is_write, 1);
    chk("io_addr", bus.mc_addr, 32'h30000);
    chk("io_wdata", bus.mc_wdata, 32'h55);
    cyc(); smp(); chk("io_c12_done", bus.lsb_done, 0);
    cyc(); bus.lsb_req = 1'b0;
    smp(); chk("io_done", bus.lsb_done, 1); chk("io_rdata", bus.lsb_rdata, 0);
    // fetch and LSB byte load held together: fetch, LSB, fetch
    cyc();
    bus.if_req = 1'b1; bus.if_addr = 32'h104; bus.lsb_req = 1'b1; bus.lsb_we = 1'b0;
    bus.lsb_addr = 32'h200; bus.lsb_type = 3'b000; rdata_v = 32'hA0A0A0A0;
    cyc(); smp(); chk("rr_first_task", bus.mc_new_task, 1); chk("rr_first_addr", bus.mc_addr, 32'h104);
    cyc(); cyc(); cyc(); cyc();
    bus.if_addr = 32'h108; rdata_v = 32'h000000C3;
    smp(); chk("rr_if_done", bus.if_done, 1); chk("rr_if_data", bus.if_data, 32'hA0A0A0A0);
    cyc(); smp(); chk("rr_second_task", bus.mc_new_task, 1); chk("rr_second_addr", bus.mc_addr, 32'h200);
    chk("rr_second_wt", bus.mc_work_type, 3'b000);
    cyc(); cyc();
    bus.lsb_req = 1'b0; rdata_v = 32'hB1B1B1B1;
    smp(); chk("rr_lsb_done", bus.lsb_done, 1); chk("rr_lsb_rdata", bus.lsb_rdata, 32'h000000C3);
    chk("rr_if_hold", bus.if_data, 32'hA0A0A0A0);
    cyc(); smp(); chk("rr_third_task", bus.mc_new_task, 1); chk("rr_third_addr", bus.mc_addr, 32'h108);
    cyc(); cyc(); cyc(); cyc();
    bus.if_req = 1'b0;
    smp(); chk("rr_if_done2", bus.if_done, 1); chk("rr_if_data2", bus.if_data, 32'hB1B1B1B1);
    chk("rr_lsb_hold", bus.lsb_rdata, 32'h000000C3);
    // word load aborted by rob_clear in WAIT, then a fetch
    cyc();
    bus.lsb_req = 1'b1; bus.lsb_we = 1'b0; bus.lsb_addr = 32'h300; bus.lsb_type = 3'b010;
    rdata_v = 32'hCAFEF00D;
    cyc(); smp(); chk("ab_issue", bus.mc_new_task, 1); chk("ab_addr", bus.mc_addr, 32'h300);
    cyc(); cyc(); bus.rob_clear = 1'b1;
    smp(); chk("ab_c3_done", bus.lsb_done, 0);
    cyc(); bus.rob_clear = 1'b0; bus.lsb_req = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'h400;
    smp(); chk("ab_c4_done", bus.lsb_done, 0); chk("ab_c4_task", bus.mc_new_task, 0);
    cyc(); smp(); chk("ab_c5_done", bus.lsb_done, 0); chk("ab_fetch_task", bus.mc_new_task, 1);
    chk("ab_fetch_addr", bus.mc_addr, 32'h400);
    cyc(); cyc(); cyc(); cyc();
    bus.if_req = 1'b0;
    smp(); chk("ab_if_done", bus.if_done, 1); chk("ab_if_data", bus.if_data, 32'hCAFEF00D);
    chk("ab_no_lsb_done", bus.lsb_done, 0); chk("ab_lsb_hold", bus.lsb_rdata, 32'h000000C3);
    // flush blocks a fetch grant, yet a store is granted and retried in ISSUE
    cyc();
    bus.if_req = 1'b1; bus.if_addr = 32'h600; bus.rob_clear = 1'b1;
    cyc(); smp(); chk("fl_no_fetch", bus.mc_addr, 32'h400); chk("fl_no_task", bus.mc_new_task, 0);
    cyc();
    bus.if_req = 1'b0; bus.lsb_req = 1'b1; bus.lsb_we = 1'b1; bus.lsb_addr = 32'h500;
    bus.lsb_wdata = 32'h1234; bus.lsb_type = 3'b001;
    smp(); chk("st_c0_task", bus.mc_new_task, 0);
    cyc(); smp(); chk("st_c1_task", bus.mc_new_task, 0); chk("st_granted", bus.mc_addr, 32'h500);
    cyc(); smp(); chk("st_c2_task", bus.mc_new_task, 0);
    cyc(); bus.rob_clear = 1'b0;
    smp(); chk("st_issue", bus.mc_new_task, 1); chk("st_dir", bus.mc_is_write, 1);
    chk("st_wdata", bus.mc_wdata, 32'h1234); chk("st_wt", bus.mc_work_type, 3'b001);
    cyc(); cyc(); smp(); chk("st_c5_done", bus.lsb_done, 0);
    cyc(); bus.lsb_req = 1'b0;
    smp(); chk("st_done", bus.lsb_done, 1); chk("st_rdata_hold", bus.lsb_rdata, 32'h000000C3);
    cyc(); smp(); chk("st_pulse", bus.lsb_done, 0);
    // rdy_in low for 4 cycles in WAIT delays a word fetch by 4 cycles
    cyc();
    bus.if_req = 1'b1; bus.if_addr = 32'h700; rdata_v = 32'h0BADF00D;
    cyc(); smp(); chk("rdy_issue", bus.mc_new_task, 1);
    cyc(); cyc(); bus.rdy_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      smp(); chk("rdy_frozen", bus.if_done, 0);
      cyc();
    end
    bus.rdy_in = 1'b1;
    smp(); chk("rdy_c7_done", bus.if_done, 0);
    cyc(); smp(); chk("rdy_c8_done", bus.if_done, 0);
    cyc(); bus.if_req = 1'b0;
    smp(); chk("rdy_done", bus.if_done, 1); chk("rdy_data", bus.if_data, 32'h0BADF00D);
    cyc(); smp(); chk("rdy_pulse", bus.if_done, 0);
`ifdef MEM_ARB_PERF_EN
    chk("perf_if", perf_if_grants, 5);
    chk("perf_lsb", perf_lsb_grants, 4);
    chk("perf_io", perf_io_stall, 10);
`endif
    // rdy_in low in ISSUE suppresses the strobe; async reset in WAIT clears everything
    cyc();
    bus.lsb_req = 1'b1; bus.lsb_we = 1'b0; bus.lsb_addr = 32'h800; bus.lsb_type = 3'b010;
    rdata_v = 32'h77;
    cyc(); bus.rdy_in = 1'b0;
    smp(); chk("rdy_issue_gate", bus.mc_new_task, 0);
    cyc(); bus.rdy_in = 1'b1;
    smp(); chk("rst_pre_task", bus.mc_new_task, 1); chk("rst_pre_addr", bus.mc_addr, 32'h800);
    cyc();
    rst_n_in = 1'b0;
    #2;
    chk("arst_addr", bus.mc_addr, 0);
    chk("arst_wdata", bus.mc_wdata, 0);
    chk("arst_wt", bus.mc_work_type, 0);
    chk("arst_task", bus.mc_new_task, 0);
    chk("arst_if_data", bus.if_data, 0);
    chk("arst_lsb_rdata", bus.lsb_rdata, 0);
    chk("arst_lsb_done", bus.lsb_done, 0);
    cyc();
    rst_n_in = 1'b1; bus.lsb_addr = 32'h200; bus.lsb_type = 3'b000;
    bus.if_req = 1'b1; bus.if_addr = 32'h900;
    cyc(); smp(); chk("post_rst_fetch_first", bus.mc_addr, 32'h900); chk("post_rst_task", bus.mc_new_task, 1);
    chk("no_overlap", overlap, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
